input_debouncer: RTL and testbench
==================================

# input_debouncer

Synchronises and debounces one raw asynchronous input (button, switch, external strobe) into a clean single-bit level in the `clk` domain. It sits directly upstream of the edge detector: `level_o` drives the detector's `a_i`, so every level change seen downstream is glitch-free and stable. It also counts rejected glitches for diagnostics.

## Interface
- `SYNC_STAGES`, 2: synchroniser flop count; legal values are 2 or more.
- `DEBOUNCE_CYCLES`, 16: number of consecutive equal synchronised samples required to accept a new level; legal values are 2 or more.
- `GLITCH_W`, 8: width of the glitch counter.
- `clk` input 1: single clock; all state updates on its rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `a_raw_i` input 1: raw asynchronous input; no timing relation to `clk`.
- `glitch_clr_i` input 1: synchronous clear of `glitch_cnt_o`.
- `level_o` output 1: debounced level, registered.
- `busy_o` output 1: high while a candidate level change is being qualified (CHK states).
- `glitch_cnt_o` output `GLITCH_W`: saturating count of rejected candidates.

## Operation
- **Synchroniser.** `a_raw_i` passes through a chain of `SYNC_STAGES` flops. The last stage is `s`. No other logic reads `a_raw_i` directly.
- **State machine.** Four states: STABLE_LO, CHK_HI, STABLE_HI, CHK_LO. The qualify counter `cnt` is `$clog2(DEBOUNCE_CYCLES)` bits wide.
  - STABLE_LO: if `s`=1, go to CHK_HI with `cnt`=1 (first high sample). Otherwise stay.
  - CHK_HI, `s`=1: if `cnt`==DEBOUNCE_CYCLES-1, go to STABLE_HI and set `level_o`<=1. Otherwise `cnt`++.
  - CHK_HI, `s`=0: return to STABLE_LO, clear `cnt`, and count a glitch.
  - STABLE_HI and CHK_LO mirror the two states above with polarity inverted. `level_o`<=0 on acceptance.
- **Output decoding.**
  - `busy_o` = (state is CHK_HI or CHK_LO), decoded from registered state.
  - `level_o` changes only on the acceptance transition. It never toggles during CHK states.
- **Glitch counter.**
  - Increments by 1 on every CHK→STABLE return (rejected candidate).
  - Saturates at 2^GLITCH_W-1 and never wraps.
  - `glitch_clr_i` sets it to 0 on the next edge.
  - If `glitch_clr_i` and a glitch occur in the same cycle, clear wins: the result is 0.
- **Reset.** Asserting `reset_n`=0 at any time, including mid-qualification, immediately clears:
  - all synchroniser flops → 0
  - state → STABLE_LO, `cnt` → 0
  - `level_o` → 0, `busy_o` → 0, `glitch_cnt_o` → 0
- **Reset release.** The block resumes on the first rising edge with `reset_n`=1. An input already high at release is qualified normally: `level_o` rises after the full latency below. It does not appear high immediately.

## Timing
- Let E1 be the first rising edge that samples a new `a_raw_i` value, and assume the input stays stable afterwards.
  - `s` takes the new value after edge E(SYNC_STAGES).
  - The FSM sees its first new sample at E(SYNC_STAGES+1).
  - `level_o` changes after edge E(SYNC_STAGES+DEBOUNCE_CYCLES). With defaults, 18 edges after E1.
- `busy_o` is high from after E(SYNC_STAGES+1) until the acceptance edge. It is low in the cycle after acceptance.
- Rejection: any opposite sample in a CHK state returns to STABLE on that edge. `busy_o` drops, and `glitch_cnt_o` updates after the same edge.
- Throughput: a new candidate can begin on the edge immediately after a rejection or an acceptance.
- Pulses on `a_raw_i` shorter than one `clk` period may be missed entirely. This is acceptable and is not counted as a glitch.
- No combinational path from any input to any output.

## Test plan
Run all scenarios with `SYNC_STAGES`=2, `DEBOUNCE_CYCLES`=4, `GLITCH_W`=3.

1. **Reset values.** Assert `reset_n`=0 with `a_raw_i`=1, then release → `level_o`=0, `busy_o`=0 and `glitch_cnt_o`=0 during reset. `level_o`=1 exactly after the 6th edge following release.
2. **Clean rise and fall.** `a_raw_i` 0→1, held → `level_o` rises after edge E6 and `busy_o` is high for 3 cycles. Then 1→0, held → `level_o` falls after 6 edges. `glitch_cnt_o` stays 0.
3. **Bounce rejection.** `a_raw_i` high for 2 cycles, low for 1, then high and held → one glitch counted (`glitch_cnt_o`=1). `level_o` rises 6 edges after the final rise, with no intermediate toggle.
4. **Glitch saturation.** Apply 10 two-cycle high pulses separated by 6 low cycles → `glitch_cnt_o` reaches 7 and stays 7. `level_o` stays 0 throughout.
5. **Clear vs glitch.** Assert `glitch_clr_i` on the same edge as a rejection → `glitch_cnt_o`=0 after that edge. A later rejection gives 1.
6. **Reset mid-qualification.** Assert `reset_n`=0 while `busy_o`=1 in CHK_LO with `level_o`=1 → `level_o`=0 and `busy_o`=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/input_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : input_debouncer
// Description : Synchronises a raw asynchronous input into the clk domain,
//               debounces it with a four-state qualify FSM and counts
//               rejected candidate level changes in a saturating counter.
// Revision    : 1.0 - initial release
// ============================================================================
module input_debouncer #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int GLITCH_W        = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                a_raw_i,
    input  logic                glitch_clr_i,
    output logic                level_o,
    output logic                busy_o,
    output logic [GLITCH_W-1:0] glitch_cnt_o
);

    localparam int C_CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [C_CNT_W-1:0] C_CNT_ONE  = C_CNT_W'(1);

    typedef enum logic [1:0] {
        ST_STABLE_LO = 2'd0,
        ST_CHK_HI    = 2'd1,
        ST_STABLE_HI = 2'd2,
        ST_CHK_LO    = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    state_t                 r_state;
    logic [C_CNT_W-1:0]     r_cnt;
    logic                   r_level;
    logic                   r_busy;
    logic [GLITCH_W-1:0]    r_glitch_cnt;

    logic                   w_s;
    logic                   w_reject;
    logic                   w_glitch_full;

    // Last synchroniser stage is the only view of the raw input used below.
    assign w_s = r_sync[SYNC_STAGES-1];

    // A candidate is rejected when an opposite sample arrives while qualifying.
    assign w_reject = ((r_state == ST_CHK_HI) && !w_s) ||
                      ((r_state == ST_CHK_LO) &&  w_s);

    assign w_glitch_full = &r_glitch_cnt;

    // Multi-flop synchroniser chain; raw input enters at bit 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], a_raw_i};
        end
    end

    // Qualify FSM with registered level and busy outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_STABLE_LO;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_STABLE_LO: begin
                    if (w_s) begin
                        r_state <= ST_CHK_HI;
                        r_cnt   <= C_CNT_ONE;
                        r_busy  <= 1'b1;
                    end
                end
                ST_CHK_HI: begin
                    if (w_s) begin
                        if (r_cnt == C_CNT_LAST) begin
                            r_state <= ST_STABLE_HI;
                            r_cnt   <= '0;
                            r_level <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + C_CNT_ONE;
                        end
                    end else begin
                        r_state <= ST_STABLE_LO;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end
                end
                ST_STABLE_HI: begin
                    if (!w_s) begin
                        r_state <= ST_CHK_LO;
                        r_cnt   <= C_CNT_ONE;
                        r_busy  <= 1'b1;
                    end
                end
                ST_CHK_LO: begin
                    if (!w_s) begin
                        if (r_cnt == C_CNT_LAST) begin
                            r_state <= ST_STABLE_LO;
                            r_cnt   <= '0;
                            r_level <= 1'b0;
                            r_busy  <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + C_CNT_ONE;
                        end
                    end else begin
                        r_state <= ST_STABLE_HI;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_STABLE_LO;
                    r_cnt   <= '0;
                    r_level <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Saturating glitch counter; a clear in the same cycle as a reject wins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_glitch_cnt <= '0;
        end else if (glitch_clr_i) begin
            r_glitch_cnt <= '0;
        end else if (w_reject && !w_glitch_full) begin
            r_glitch_cnt <= r_glitch_cnt + GLITCH_W'(1);
        end
    end

    assign level_o      = r_level;
    assign busy_o       = r_busy;
    assign glitch_cnt_o = r_glitch_cnt;

endmodule
`default_nettype wire

// File: tb/tb_input_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : tb_input_debouncer
// Description : Directed, table-driven bench for input_debouncer with
//               SYNC_STAGES=2, DEBOUNCE_CYCLES=4, GLITCH_W=3.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_input_debouncer;

    localparam int C_SS = 2;
    localparam int C_DC = 4;
    localparam int C_GW = 3;

    logic            clk;
    logic            reset_n;
    logic            a_raw_i;
    logic            glitch_clr_i;
    logic            level_o;
    logic            busy_o;
    logic [C_GW-1:0] glitch_cnt_o;

    int total;
    int bad;

    input_debouncer #(
        .SYNC_STAGES    (C_SS),
        .DEBOUNCE_CYCLES(C_DC),
        .GLITCH_W       (C_GW)
    ) u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .a_raw_i     (a_raw_i),
        .glitch_clr_i(glitch_clr_i),
        .level_o     (level_o),
        .busy_o      (busy_o),
        .glitch_cnt_o(glitch_cnt_o)
    );

    // 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit       raw;
        bit       clr;
        bit       exp_level;
        bit       exp_busy;
        bit [2:0] exp_glitch;
    } vec_t;

    vec_t vecs[32];

    task automatic check(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Advance one rising edge; outputs are sampled 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setv(input int i, input bit raw, input bit clr,
                        input bit lvl, input bit bsy, input bit [2:0] g);
        vecs[i].raw        = raw;
        vecs[i].clr        = clr;
        vecs[i].exp_level  = lvl;
        vecs[i].exp_busy   = bsy;
        vecs[i].exp_glitch = g;
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        reset_n      = 1'b0;
        a_raw_i      = 1'b1;
        glitch_clr_i = 1'b0;

        // Clean rise then fall from an idle low state.
        setv( 0, 1, 0, 0, 0, 0);
        setv( 1, 1, 0, 0, 0, 0);
        setv( 2, 1, 0, 0, 1, 0);
        setv( 3, 1, 0, 0, 1, 0);
        setv( 4, 1, 0, 0, 1, 0);
        setv( 5, 1, 0, 1, 0, 0);
        setv( 6, 0, 0, 1, 0, 0);
        setv( 7, 0, 0, 1, 0, 0);
        setv( 8, 0, 0, 1, 1, 0);
        setv( 9, 0, 0, 1, 1, 0);
        setv(10, 0, 0, 1, 1, 0);
        setv(11, 0, 0, 0, 0, 0);
        // Bounce: high 2, low 1, high held.
        setv(12, 1, 0, 0, 0, 0);
        setv(13, 1, 0, 0, 0, 0);
        setv(14, 0, 0, 0, 1, 0);
        setv(15, 1, 0, 0, 1, 0);
        setv(16, 1, 0, 0, 0, 1);
        setv(17, 1, 0, 0, 1, 1);
        setv(18, 1, 0, 0, 1, 1);
        setv(19, 1, 0, 0, 1, 1);
        setv(20, 1, 0, 1, 0, 1);
        // Falling bounce rejected on the same edge as a clear.
        setv(21, 0, 0, 1, 0, 1);
        setv(22, 0, 0, 1, 0, 1);
        setv(23, 1, 0, 1, 1, 1);
        setv(24, 1, 0, 1, 1, 1);
        setv(25, 1, 1, 1, 0, 0);
        setv(26, 1, 0, 1, 0, 0);
        // A later single-sample low glitch counts from zero again.
        setv(27, 0, 0, 1, 0, 0);
        setv(28, 1, 0, 1, 0, 0);
        setv(29, 1, 0, 1, 1, 0);
        setv(30, 1, 0, 1, 0, 1);
        setv(31, 1, 0, 1, 0, 1);

        // ---- Reset values with input already high ----
        #1;
        check("rst_level", int'(level_o), 0);
        check("rst_busy", int'(busy_o), 0);
        check("rst_glitch", int'(glitch_cnt_o), 0);
        tick();
        tick();
        check("rst_hold_level", int'(level_o), 0);
        check("rst_hold_glitch", int'(glitch_cnt_o), 0);
        reset_n = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            tick();
            check($sformatf("rel_level_e%0d", e), int'(level_o), (e == 6) ? 1 : 0);
            check($sformatf("rel_busy_e%0d", e), int'(busy_o), (e >= 3 && e <= 5) ? 1 : 0);
        end
        a_raw_i = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            tick();
            check($sformatf("fall_level_e%0d", e), int'(level_o), (e == 6) ? 0 : 1);
        end

        // ---- Table-driven vectors ----
        for (int i = 0; i < 32; i++) begin
            a_raw_i      = vecs[i].raw;
            glitch_clr_i = vecs[i].clr;
            tick();
            check($sformatf("v%0d_level", i), int'(level_o), int'(vecs[i].exp_level));
            check($sformatf("v%0d_busy", i), int'(busy_o), int'(vecs[i].exp_busy));
            check($sformatf("v%0d_glitch", i), int'(glitch_cnt_o), int'(vecs[i].exp_glitch));
        end
        glitch_clr_i = 1'b0;

        // ---- Asynchronous reset while qualifying a fall ----
        a_raw_i = 1'b0;
        tick();
        tick();
        tick();
        check("mid_busy", int'(busy_o), 1);
        check("mid_level", int'(level_o), 1);
        check("mid_glitch", int'(glitch_cnt_o), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_level", int'(level_o), 0);
        check("async_busy", int'(busy_o), 0);
        check("async_glitch", int'(glitch_cnt_o), 0);
        tick();
        reset_n = 1'b1;

        // ---- Glitch counter saturation ----
        for (int p = 0; p < 10; p++) begin
            a_raw_i = 1'b1;
            for (int c = 0; c < 8; c++) begin
                if (c == 2) a_raw_i = 1'b0;
                tick();
                check($sformatf("sat_p%0d_c%0d_level", p, c), int'(level_o), 0);
            end
            check($sformatf("sat_p%0d_glitch", p), int'(glitch_cnt_o), (p + 1 > 7) ? 7 : p + 1);
        end
        tick();
        check("sat_hold_glitch", int'(glitch_cnt_o), 7);

        // Clear alone returns the counter to zero.
        glitch_clr_i = 1'b1;
        tick();
        glitch_clr_i = 1'b0;
        check("clr_only_glitch", int'(glitch_cnt_o), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety net against a stalled run.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
